apb_master_arbiter: RTL and testbench

- Shares one APB master port among NUM_REQ requesters, e.g. the register-config sequencer and the interrupt-service engine.
- Arbitrates round-robin and decodes the slave select from the address.
- Sequences the APB SETUP/ACCESS phases, bounds slave wait states with a timeout, and returns read data and status to the granted requester.
- Sits between the requester-side logic and the APB slaves (SPI core registers etc.).

---
 rtl/apb_master_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with address-based slave select decode and a bounded wait-state timeout.
module apb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NUM_SLV = 16,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_we,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gnt_q;
    logic               we_q;
    logic [15:0]        cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic [NUM_SLV-1:0] psel_q;
    logic               penable_q;
    logic               pwrite_q;

    logic               pick_found_d;
    logic [PTR_W-1:0]   pick_idx_d;
    logic [PTR_W-1:0]   cand_d;
    logic [ADDR_W-1:0]  pick_addr_d;
    logic [DATA_W-1:0]  pick_wdata_d;
    logic               pick_we_d;
    logic [3:0]         slv_idx_d;
    logic               slv_ok_d;
    logic [NUM_SLV-1:0] psel_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] rsp_onehot_d;
    logic [PTR_W-1:0]   ptr_d;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        cand_d       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_d = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_found_d && req_valid[cand_d]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = cand_d;
            end
        end
    end

    always_comb begin
        pick_addr_d  = '0;
        pick_wdata_d = '0;
        pick_we_d    = 1'b0;
        grant_d      = '0;
        rsp_onehot_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pick_idx_d == PTR_W'(r)) begin
                pick_addr_d  = req_addr[r*ADDR_W +: ADDR_W];
                pick_wdata_d = req_wdata[r*DATA_W +: DATA_W];
                pick_we_d    = req_we[r];
            end
            grant_d[r]      = pick_found_d && (pick_idx_d == PTR_W'(r));
            rsp_onehot_d[r] = (gnt_q == PTR_W'(r));
        end
    end

    always_comb begin
        slv_idx_d = pick_addr_d[SEL_LSB+3:SEL_LSB];
        slv_ok_d  = int'(slv_idx_d) < NUM_SLV;
        ptr_d     = PTR_W'((int'(pick_idx_d) + 1) % NUM_REQ);
        psel_d    = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            psel_d[s] = slv_ok_d && (int'(slv_idx_d) == s);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
        end else begin
            grant_q     <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        ptr_q   <= ptr_d;
                        gnt_q   <= pick_idx_d;
                        we_q    <= pick_we_d;
                        grant_q <= grant_d;
                        cnt_q   <= '0;
                        if (slv_ok_d) begin
                            state_q  <= SETUP;
                            psel_q   <= psel_d;
                            paddr_q  <= pick_addr_d;
                            pwrite_q <= pick_we_d;
                            pwdata_q <= pick_we_d ? pick_wdata_d : '0;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY || (cnt_q == 16'(TIMEOUT - 1))) begin
                        rsp_valid_q <= rsp_onehot_d;
                        rsp_err_q   <= !PREADY;
                        rsp_rdata_q <= (PREADY && !we_q) ? PRDATA : '0;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        pwrite_q    <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ERR: begin
                    // Counter doubles as a phase bit so bad-index latency matches a zero-wait transfer.
                    if (cnt_q == 16'd0) begin
                        cnt_q <= 16'd1;
                    end else begin
                        rsp_valid_q <= rsp_onehot_d;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_grant = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed scoreboard bench for apb_master_arbiter: expected grants and
// responses are queued as requests are driven and popped as the DUT answers.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int NUM_SLV = 4;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 4;

    logic                      PCLK;
    logic                      PRESETn;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;

    typedef struct {
        int          req;
        logic        err;
        logic [15:0] rdata;
        int          lat;
    } rsp_t;

    int   grantQ[$];
    rsp_t rspQ[$];
    int   nAsserts = 0;
    int   nFails = 0;
    int   cycle = 0;
    int   grantCycle = 0;
    int   lastGrantCycle = 0;
    int   expGrantGap = 0;
    int   slvWaits = 0;
    int   waitCnt = 0;
    int   accessCnt = 0;
    int   remaining [NUM_REQ];
    bit   noPsel = 0;
    bit   grantSeen = 0;

    apb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] oneHot(input int r);
        return 32'(1) << r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int count);
        req_addr[r*ADDR_W +: ADDR_W]  = addr;
        req_wdata[r*DATA_W +: DATA_W] = wdata;
        req_we[r]    = we;
        remaining[r] = count;
        req_valid[r] = 1'b1;
    endtask

    task automatic expectTransfer(input int r, input logic err, input logic [15:0] rdata, input int lat);
        rsp_t e;
        e.req   = r;
        e.err   = err;
        e.rdata = rdata;
        e.lat   = lat;
        grantQ.push_back(r);
        rspQ.push_back(e);
    endtask

    // Per-cycle monitor, requester model and APB slave model.
    task automatic monitorCycle();
        if (req_grant != '0) begin
            grantSeen = 1'b1;
            if (grantQ.size() == 0) begin
                checkOutput("unexpected_grant", 32'(req_grant), 32'd0);
            end else begin
                int g;
                g = grantQ.pop_front();
                checkOutput("grant_onehot", 32'(req_grant), oneHot(g));
                if (expGrantGap != 0 && lastGrantCycle != 0)
                    checkOutput("grant_gap", 32'(cycle - lastGrantCycle), 32'(expGrantGap));
            end
            lastGrantCycle = cycle;
            grantCycle     = cycle;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_grant[r]) begin
                    remaining[r]--;
                    if (remaining[r] <= 0) begin
                        req_valid[r] = 1'b0;
                        req_addr[r*ADDR_W +: ADDR_W]  = 16'hFFFF;
                        req_wdata[r*DATA_W +: DATA_W] = 16'h0000;
                        req_we[r] = ~req_we[r];
                    end
                end
            end
        end
        if (rsp_valid != '0) begin
            if (rspQ.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = rspQ.pop_front();
                checkOutput("rsp_valid_onehot", 32'(rsp_valid), oneHot(e.req));
                checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                checkOutput("rsp_latency", 32'(cycle - grantCycle), 32'(e.lat));
            end
        end
        if (noPsel) checkOutput("bad_index_psel", 32'(PSEL), 32'd0);
        if (PENABLE && PSEL != '0) accessCnt++;
        if (PENABLE) begin
            PREADY = (waitCnt >= slvWaits);
            waitCnt++;
        end else begin
            PREADY  = 1'b0;
            waitCnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        cycle++;
        monitorCycle();
    endtask

    task automatic waitGrant(input int maxCyc);
        grantSeen = 1'b0;
        for (int i = 0; i < maxCyc && !grantSeen; i++) tick();
        checkOutput("grant_seen", 32'(grantSeen), 32'd1);
    endtask

    task automatic runUntilDone(input int maxCyc);
        for (int i = 0; i < maxCyc && (rspQ.size() > 0 || grantQ.size() > 0); i++) tick();
        checkOutput("pending_expectations", 32'(rspQ.size() + grantQ.size()), 32'd0);
        rspQ.delete();
        grantQ.delete();
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_we    = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) remaining[r] = 0;
        #12;
        checkOutput("reset_req_grant", 32'(req_grant), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_psel", 32'(PSEL), 32'd0);
        checkOutput("reset_penable", 32'(PENABLE), 32'd0);
        checkOutput("reset_pwrite", 32'(PWRITE), 32'd0);
        checkOutput("reset_paddr", 32'(PADDR), 32'd0);
        checkOutput("reset_pwdata", 32'(PWDATA), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        tick();
        PRESETn = 1'b1;
        tick();

        $display("[TB] single zero-wait write");
        slvWaits = 0;
        applyStimulus(0, 1'b1, 16'h1004, 16'hBEEF, 1);
        expectTransfer(0, 1'b0, 16'h0000, 2);
        waitGrant(5);
        checkOutput("wr_setup_psel", 32'(PSEL), 32'h2);
        checkOutput("wr_setup_paddr", 32'(PADDR), 32'h1004);
        checkOutput("wr_setup_pwrite", 32'(PWRITE), 32'd1);
        checkOutput("wr_setup_penable", 32'(PENABLE), 32'd0);
        checkOutput("wr_setup_pwdata", 32'(PWDATA), 32'hBEEF);
        tick();
        checkOutput("wr_access_penable", 32'(PENABLE), 32'd1);
        checkOutput("wr_access_paddr_latched", 32'(PADDR), 32'h1004);
        checkOutput("wr_access_pwdata_latched", 32'(PWDATA), 32'hBEEF);
        runUntilDone(10);
        checkOutput("wr_done_psel", 32'(PSEL), 32'd0);

        $display("[TB] read with three wait states");
        slvWaits  = 3;
        PRDATA    = 16'h5A5A;
        accessCnt = 0;
        applyStimulus(1, 1'b0, 16'h2000, 16'h1234, 1);
        expectTransfer(1, 1'b0, 16'h5A5A, 5);
        waitGrant(5);
        checkOutput("rd_setup_psel", 32'(PSEL), 32'h4);
        checkOutput("rd_setup_pwrite", 32'(PWRITE), 32'd0);
        checkOutput("rd_setup_pwdata", 32'(PWDATA), 32'd0);
        runUntilDone(20);
        checkOutput("rd_access_cycles", 32'(accessCnt), 32'd4);
        tick();
        tick();
        checkOutput("rd_rdata_hold", 32'(rsp_rdata), 32'h5A5A);

        $display("[TB] round-robin with both requesters valid");
        slvWaits       = 0;
        PRDATA         = 16'h0C0C;
        expGrantGap    = 3;
        lastGrantCycle = 0;
        for (int n = 0; n < 3; n++) begin
            expectTransfer(0, 1'b0, 16'h0000, 2);
            expectTransfer(1, 1'b0, 16'h0C0C, 2);
        end
        applyStimulus(0, 1'b1, 16'h1000, 16'h0A0A, 3);
        applyStimulus(1, 1'b0, 16'h3002, 16'h0000, 3);
        runUntilDone(60);
        expGrantGap = 0;

        $display("[TB] timeout with PREADY stuck low");
        slvWaits  = 1000;
        PRDATA    = 16'hDEAD;
        accessCnt = 0;
        applyStimulus(0, 1'b0, 16'h3000, 16'h0000, 1);
        expectTransfer(0, 1'b1, 16'h0000, 1 + TIMEOUT);
        runUntilDone(30);
        checkOutput("to_access_cycles", 32'(accessCnt), 32'(TIMEOUT));
        checkOutput("to_psel_released", 32'(PSEL), 32'd0);
        checkOutput("to_penable_released", 32'(PENABLE), 32'd0);

        $display("[TB] bad slave index");
        noPsel = 1'b1;
        applyStimulus(1, 1'b0, 16'h5000, 16'h0000, 1);
        expectTransfer(1, 1'b1, 16'h0000, 2);
        runUntilDone(20);
        noPsel = 1'b0;

        $display("[TB] reset in the middle of ACCESS");
        slvWaits = 1000;
        applyStimulus(0, 1'b1, 16'h1008, 16'h1111, 1);
        expectTransfer(0, 1'b0, 16'h0000, 2);
        waitGrant(5);
        tick();
        checkOutput("pre_reset_penable", 32'(PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_psel", 32'(PSEL), 32'd0);
        checkOutput("async_reset_penable", 32'(PENABLE), 32'd0);
        checkOutput("async_reset_grant", 32'(req_grant), 32'd0);
        checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("async_reset_paddr", 32'(PADDR), 32'd0);
        rspQ.delete();
        grantQ.delete();
        tick();
        tick();
        PRESETn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        slvWaits = 0;
        PRDATA   = 16'h7777;
        expectTransfer(0, 1'b0, 16'h0000, 2);
        expectTransfer(1, 1'b0, 16'h7777, 2);
        applyStimulus(1, 1'b0, 16'h2000, 16'h0000, 1);
        applyStimulus(0, 1'b1, 16'h1000, 16'h4321, 1);
        runUntilDone(30);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
